// File: rtl/mem_port_arbiter_if.sv
// Bus bundle for mem_port_arbiter: two requester ports, the shared memory
// port and the arbiter status outputs. The arbiter connects through the
// slave modport; the surrounding core/memory model uses the master modport.
interface mem_port_arbiter_if #(
    parameter int AW = 32,
    parameter int DW = 32
);
    logic          req0;
    logic [AW-1:0] addr0;
    logic          we0;
    logic [DW-1:0] wdata0;
    logic          ack0;

    logic          req1;
    logic [AW-1:0] addr1;
    logic          we1;
    logic [DW-1:0] wdata1;
    logic          ack1;

    logic [DW-1:0] rdata;
    logic          err;
    logic          sel;
    logic          busy;

    logic          mem_valid;
    logic [AW-1:0] mem_addr;
    logic          mem_we;
    logic [DW-1:0] mem_wdata;
    logic          mem_ready;
    logic [DW-1:0] mem_rdata;

    modport slave (
        input  req0, addr0, we0, wdata0,
        input  req1, addr1, we1, wdata1,
        input  mem_ready, mem_rdata,
        output ack0, ack1, rdata, err, sel, busy,
        output mem_valid, mem_addr, mem_we, mem_wdata
    );

    modport master (
        output req0, addr0, we0, wdata0,
        output req1, addr1, we1, wdata1,
        output mem_ready, mem_rdata,
        input  ack0, ack1, rdata, err, sel, busy,
        input  mem_valid, mem_addr, mem_we, mem_wdata
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one memory port between instruction fetch
// (port 0) and load/store (port 1) with round-robin arbitration.
// A grant registers the winner's address/data onto the memory side,
// the memory handshake runs in BUSY, and a one-cycle ack with read data
// is returned in ACK.
// Optional feature: define MEM_TIMEOUT_EN to abort a BUSY transaction
// with err=1 once the wait counter reaches MAX_WAIT.
module mem_port_arbiter #(
    parameter int AW       = 32,
    parameter int DW       = 32,
    parameter int MAX_WAIT = 15
) (
    input logic              clk,
    input logic              rst_n,
    mem_port_arbiter_if.slave bus
);

    if (MAX_WAIT < 1 || MAX_WAIT > 255) begin : g_bad_max_wait
        $error("mem_port_arbiter: MAX_WAIT must be in 1..255");
    end

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        ACK  = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic          sel_q, sel_d;
    logic          prio_q, prio_d;      // port that wins the next contested grant
    logic [AW-1:0] mem_addr_q, mem_addr_d;
    logic          mem_we_q, mem_we_d;
    logic [DW-1:0] mem_wdata_q, mem_wdata_d;
    logic [DW-1:0] rdata_q, rdata_d;
    logic          winner;

`ifdef MEM_TIMEOUT_EN
    localparam logic [7:0] WAIT_LIMIT = 8'(MAX_WAIT);
    logic [7:0]    wait_q, wait_d;
    logic          err_q, err_d;
`endif

    // Contested requests go to the priority pointer, otherwise to whoever asks.
    assign winner = (bus.req0 && bus.req1) ? prio_q : bus.req1;

    // Next-state logic: grant in IDLE, memory handshake in BUSY, ack pulse in ACK.
    always_comb begin
        state_d     = state_q;
        sel_d       = sel_q;
        prio_d      = prio_q;
        mem_addr_d  = mem_addr_q;
        mem_we_d    = mem_we_q;
        mem_wdata_d = mem_wdata_q;
        rdata_d     = '0;
`ifdef MEM_TIMEOUT_EN
        wait_d      = wait_q;
        err_d       = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                if (bus.req0 || bus.req1) begin
                    sel_d       = winner;
                    prio_d      = ~winner;
                    mem_addr_d  = winner ? bus.addr1  : bus.addr0;
                    mem_we_d    = winner ? bus.we1    : bus.we0;
                    mem_wdata_d = winner ? bus.wdata1 : bus.wdata0;
                    state_d     = BUSY;
`ifdef MEM_TIMEOUT_EN
                    wait_d      = '0;
`endif
                end
            end
            BUSY: begin
                if (bus.mem_ready) begin
                    // Writes return zero so stale bus data never leaks to the LSU.
                    rdata_d = mem_we_q ? '0 : bus.mem_rdata;
                    state_d = ACK;
                end
`ifdef MEM_TIMEOUT_EN
                else if (wait_q == WAIT_LIMIT) begin
                    err_d   = 1'b1;
                    state_d = ACK;
                end else begin
                    wait_d = wait_q + 8'd1;
                end
`endif
            end
            ACK: begin
                // Requests are deliberately not sampled here, so a held req
                // cannot be re-granted back to back.
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers; reset drops any outstanding transaction.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            sel_q       <= 1'b0;
            prio_q      <= 1'b0;
            mem_addr_q  <= '0;
            mem_we_q    <= 1'b0;
            mem_wdata_q <= '0;
            rdata_q     <= '0;
`ifdef MEM_TIMEOUT_EN
            wait_q      <= '0;
            err_q       <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            sel_q       <= sel_d;
            prio_q      <= prio_d;
            mem_addr_q  <= mem_addr_d;
            mem_we_q    <= mem_we_d;
            mem_wdata_q <= mem_wdata_d;
            rdata_q     <= rdata_d;
`ifdef MEM_TIMEOUT_EN
            wait_q      <= wait_d;
            err_q       <= err_d;
`endif
        end
    end

    assign bus.mem_valid = (state_q == BUSY);
    assign bus.busy      = (state_q != IDLE);
    assign bus.ack0      = (state_q == ACK) && !sel_q;
    assign bus.ack1      = (state_q == ACK) &&  sel_q;
    assign bus.sel       = sel_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_we    = mem_we_q;
    assign bus.mem_wdata = mem_wdata_q;
    assign bus.rdata     = rdata_q;
`ifdef MEM_TIMEOUT_EN
    assign bus.err       = err_q;
`else
    assign bus.err       = 1'b0;
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Randomized self-checking bench for mem_port_arbiter. The reference is a
// transaction-level model: a pending-request table per port, a "favoured
// port" for contests, and per-transaction expectations for grant, memory
// phase and ack. Works with or without MEM_TIMEOUT_EN.
module tb_mem_port_arbiter;
    localparam int AW       = 32;
    localparam int DW       = 32;
    localparam int MAX_WAIT = 15;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    mem_port_arbiter_if #(.AW(AW), .DW(DW)) bus();

    mem_port_arbiter #(.AW(AW), .DW(DW), .MAX_WAIT(MAX_WAIT)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model state
    int            favour = 0;          // port that wins the next contest
    logic          pend   [2];
    logic [AW-1:0] addr_v [2];
    logic          we_v   [2];
    logic [DW-1:0] wd_v   [2];

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // The two acks must never coincide
    always @(negedge clk) begin
        if (rst_n) chk("ack_excl", 64'(bus.ack0 & bus.ack1), 64'd0);
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic post(input int p, input logic [AW-1:0] a, input logic we, input logic [DW-1:0] wd);
        pend[p] = 1'b1; addr_v[p] = a; we_v[p] = we; wd_v[p] = wd;
        if (p == 0) begin bus.req0 = 1'b1; bus.addr0 = a; bus.we0 = we; bus.wdata0 = wd; end
        else        begin bus.req1 = 1'b1; bus.addr1 = a; bus.we1 = we; bus.wdata1 = wd; end
    endtask

    task automatic unreq(input int p);
        pend[p] = 1'b0;
        if (p == 0) bus.req0 = 1'b0; else bus.req1 = 1'b0;
    endtask

    // Round-robin rule: contest -> favoured port; any grant favours the loser next.
    task automatic predict_grant(output int w);
        if (pend[0] && pend[1]) w = favour;
        else                    w = pend[1] ? 1 : 0;
        favour = 1 - w;
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, "_busy"},  64'(bus.busy),      64'd0);
        chk({tag, "_valid"}, 64'(bus.mem_valid), 64'd0);
        chk({tag, "_ack0"},  64'(bus.ack0),      64'd0);
        chk({tag, "_ack1"},  64'(bus.ack1),      64'd0);
        chk({tag, "_rdata"}, 64'(bus.rdata),     64'd0);
        chk({tag, "_err"},   64'(bus.err),       64'd0);
    endtask

    task automatic chk_all_zero(input string tag);
        chk_idle(tag);
        chk({tag, "_sel"},   64'(bus.sel),       64'd0);
        chk({tag, "_addr"},  64'(bus.mem_addr),  64'd0);
        chk({tag, "_we"},    64'(bus.mem_we),    64'd0);
        chk({tag, "_wdata"}, 64'(bus.mem_wdata), 64'd0);
    endtask

    // One full transaction from an IDLE cycle with at least one pending request.
    task automatic serve(input int waits, input logic [DW-1:0] rd, input logic scramble, input logic drop);
        int            w;
        logic [AW-1:0] ea;
        logic          ewe;
        logic [DW-1:0] ewd;
        predict_grant(w);
        ea = addr_v[w]; ewe = we_v[w]; ewd = wd_v[w];
        step();
        chk("grant_valid", 64'(bus.mem_valid), 64'd1);
        chk("grant_busy",  64'(bus.busy),      64'd1);
        chk("grant_sel",   64'(bus.sel),       64'(w));
        chk("grant_addr",  64'(bus.mem_addr),  64'(ea));
        chk("grant_we",    64'(bus.mem_we),    64'(ewe));
        chk("grant_wdata", 64'(bus.mem_wdata), 64'(ewd));
        if (scramble) begin
            if (w == 0) begin bus.addr0 = ~ea; bus.we0 = ~ewe; bus.wdata0 = ~ewd; end
            else        begin bus.addr1 = ~ea; bus.we1 = ~ewe; bus.wdata1 = ~ewd; end
        end
        if (drop) unreq(w);
        for (int i = 0; i < waits; i++) begin
            bus.mem_ready = 1'b0;
            bus.mem_rdata = $urandom;
            step();
            chk("wait_valid", 64'(bus.mem_valid), 64'd1);
            chk("wait_addr",  64'(bus.mem_addr),  64'(ea));
            chk("wait_wdata", 64'(bus.mem_wdata), 64'(ewd));
            chk("wait_we",    64'(bus.mem_we),    64'(ewe));
            chk("wait_noack", 64'(bus.ack0 | bus.ack1), 64'd0);
        end
        bus.mem_ready = 1'b1;
        bus.mem_rdata = rd;
        step();
        chk("ack0",      64'(bus.ack0),      64'(w == 0));
        chk("ack1",      64'(bus.ack1),      64'(w == 1));
        chk("ack_rdata", 64'(bus.rdata),     ewe ? 64'd0 : 64'(rd));
        chk("ack_err",   64'(bus.err),       64'd0);
        chk("ack_valid", 64'(bus.mem_valid), 64'd0);
        bus.mem_ready = 1'b0;
        bus.mem_rdata = $urandom;
        unreq(w);
        step();
        chk_idle("post_ack");
    endtask

    initial begin
        int w;
        bus.req0 = 0; bus.addr0 = '0; bus.we0 = 0; bus.wdata0 = '0;
        bus.req1 = 0; bus.addr1 = '0; bus.we1 = 0; bus.wdata1 = '0;
        bus.mem_ready = 0; bus.mem_rdata = '0;
        pend[0] = 0; pend[1] = 0;

        // Reset state
        #2;
        chk_all_zero("reset");
        step(); step();
        #2 rst_n = 1'b1;
        step();
        chk_all_zero("after_reset");

        // Contention straight after reset: grants 0,1,0,1
        post(0, 32'h1000, 0, '0);
        post(1, 32'h2000, 0, '0);
        for (int i = 0; i < 4; i++) begin
            serve(0, $urandom, 0, 0);
            if (i % 2 == 0) post(0, 32'h1000 + 32'(i), 0, '0);
            else            post(1, 32'h2000 + 32'(i), 0, '0);
        end
        unreq(0); unreq(1);

        // Single read with zero-wait memory
        post(0, 32'h100, 0, '0);
        serve(0, 32'hDEADBEEF, 0, 0);

        // Write with 4 delayed ready cycles: 5 valid cycles, rdata 0
        post(1, 32'h300, 1, 32'h5A5A5A5A);
        serve(4, 32'hFFFF_0000, 0, 0);

        // Inputs changed and req dropped while BUSY
        post(0, 32'h400, 0, '0);
        serve(2, 32'h1234_5678, 1, 1);

        // Random traffic
        for (int it = 0; it < 300; it++) begin
            for (int p = 0; p < 2; p++)
                if (!pend[p] && $urandom_range(0, 1) == 1)
                    post(p, $urandom, 1'($urandom_range(0, 1)), $urandom);
            if (!pend[0] && !pend[1]) begin
                step();
                chk_idle("rnd_idle");
            end else begin
                serve(int'($urandom_range(0, 3)), $urandom,
                      1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) == 0));
            end
        end
        unreq(0); unreq(1);
        step();

        // Memory never answers
        post(0, 32'h500, 0, '0);
        predict_grant(w);
        step();
        chk("stall_grant", 64'(bus.mem_valid), 64'd1);
`ifdef MEM_TIMEOUT_EN
        for (int i = 0; i < MAX_WAIT; i++) begin
            step();
            chk("to_valid", 64'(bus.mem_valid), 64'd1);
            chk("to_noack", 64'(bus.ack0 | bus.ack1), 64'd0);
        end
        step();
        chk("to_ack0",  64'(bus.ack0),      64'(w == 0));
        chk("to_err",   64'(bus.err),       64'd1);
        chk("to_rdata", 64'(bus.rdata),     64'd0);
        chk("to_valid_drop", 64'(bus.mem_valid), 64'd0);
        unreq(0);
        step();
        chk_idle("to_post");
        post(0, 32'h600, 0, '0);
        predict_grant(w);
        step();
        chk("stall2_grant", 64'(bus.mem_valid), 64'd1);
`else
        for (int i = 0; i < 40; i++) begin
            step();
            chk("hang_busy",  64'(bus.busy),      64'd1);
            chk("hang_valid", 64'(bus.mem_valid), 64'd1);
            chk("hang_noack", 64'(bus.ack0 | bus.ack1), 64'd0);
        end
`endif

        // Asynchronous reset in the middle of BUSY
        #3 rst_n = 1'b0;
        #1;
        chk_all_zero("mid_reset");
        unreq(0); unreq(1);
        favour = 0;
        step();
        #2 rst_n = 1'b1;
        bus.mem_ready = 1'b1;
        bus.mem_rdata = 32'hCAFEF00D;
        for (int i = 0; i < 4; i++) begin
            step();
            chk_idle("reset_recover");
        end
        bus.mem_ready = 1'b0;

        // First contest after this reset goes to port 0 again
        post(1, 32'h700, 0, '0);
        post(0, 32'h800, 0, '0);
        serve(1, 32'h0BADCAFE, 0, 0);
        serve(0, 32'h600DF00D, 0, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
